// File: rtl/issue_scoreboard_control_if.sv
// Fetch / decode / writeback handshake bundle for issue_scoreboard_control.
// The slave modport is the control block; master is whatever drives it.
interface issue_scoreboard_control_if #(
  parameter int SB_DEPTH = 4
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic             iInstructionAvailable;
  logic [63:0]      iEncodedInstruction;
  logic             oInstructionAccepted;
  logic             oIssue;
  logic [63:0]      oInstruction;
  logic             iExeBusy;
  logic             iWritebackValid;
  logic [15:0]      iWritebackAddress;
  logic             iFlush;
  logic [CNT_W-1:0] oPendingCount;
  logic             oStalled;
  logic [15:0]      oStallCycles;
  logic             oError;

  modport master (
    output iInstructionAvailable, iEncodedInstruction, iExeBusy,
           iWritebackValid, iWritebackAddress, iFlush,
    input  oInstructionAccepted, oIssue, oInstruction, oPendingCount,
           oStalled, oStallCycles, oError
  );

  modport slave (
    input  iInstructionAvailable, iEncodedInstruction, iExeBusy,
           iWritebackValid, iWritebackAddress, iFlush,
    output oInstructionAccepted, oIssue, oInstruction, oPendingCount,
           oStalled, oStallCycles, oError
  );
endinterface

// File: rtl/issue_scoreboard_control.sv
// Holds one fetched instruction and releases it to decode once no in-flight
// write (tracked in an in-order scoreboard) conflicts with it.
module issue_scoreboard_control #(
  parameter int SB_DEPTH     = 4,
  parameter bit FWD_YOUNGEST = 1'b1,
  parameter int IMM_BITPOS   = 62
) (
  input  logic                      Clock,
  input  logic                      Reset,
  issue_scoreboard_control_if.slave bus
);
  localparam int IDX_W = $clog2(SB_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [63:0]      instr_q, instr_d;
  logic [15:0]      sb_dest_q [SB_DEPTH];
  logic [15:0]      sb_dest_d [SB_DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      stall_cycles_q, stall_cycles_d;
  logic             error_q, error_d;

  logic             held, imm, raw_hit, waw_hit, hazard, sb_full;
  logic             issue, accept, stalled, wb_ok, wb_bad;
  logic [15:0]      held_dest, chk_a, chk_b;
  logic [IDX_W-1:0] youngest, offs;

  // Hazard detection works only from registered state, so a same-cycle
  // writeback never unblocks the held instruction until the next cycle.
  always_comb begin
    held      = (state_q == ST_HELD);
    imm       = instr_q[IMM_BITPOS];
    held_dest = instr_q[47:32];
    chk_a     = imm ? held_dest : instr_q[15:0];
    chk_b     = imm ? held_dest : instr_q[31:16];
    youngest  = tail_q - IDX_W'(1);
    raw_hit   = 1'b0;
    waw_hit   = 1'b0;
    offs      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      offs = IDX_W'(i) - head_q;
      if ({1'b0, offs} < count_q) begin
        if (sb_dest_q[i] == held_dest) waw_hit = 1'b1;
        if (!(FWD_YOUNGEST && (IDX_W'(i) == youngest)) &&
            ((sb_dest_q[i] == chk_a) || (sb_dest_q[i] == chk_b)))
          raw_hit = 1'b1;
      end
    end
    hazard  = raw_hit | waw_hit;
    sb_full = (count_q == CNT_W'(SB_DEPTH));
    issue   = held & ~hazard & ~bus.iExeBusy & ~sb_full & ~bus.iFlush;
    accept  = bus.iInstructionAvailable & ~bus.iFlush & (~held | issue) & ~Reset;
    stalled = held & ~issue & ~bus.iFlush;
  end

  // A mismatching or empty-scoreboard writeback only flags the error; the
  // scoreboard keeps its contents so later correct retirements still line up.
  always_comb begin
    wb_ok  = bus.iWritebackValid && (count_q != '0) &&
             (bus.iWritebackAddress == sb_dest_q[head_q]);
    wb_bad = bus.iWritebackValid & ~wb_ok;
    for (int i = 0; i < SB_DEPTH; i++) sb_dest_d[i] = sb_dest_q[i];
    if (issue) sb_dest_d[tail_q] = held_dest;
    tail_d  = issue ? tail_q + IDX_W'(1) : tail_q;
    head_d  = wb_ok ? head_q + IDX_W'(1) : head_q;
    count_d = count_q + CNT_W'(issue) - CNT_W'(wb_ok);
    error_d = error_q | wb_bad;
    stall_cycles_d = (stalled && (stall_cycles_q != 16'hFFFF)) ?
                     stall_cycles_q + 16'd1 : stall_cycles_q;
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    if (bus.iFlush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_HELD;
      instr_d = bus.iEncodedInstruction;
    end else if (issue) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= ST_EMPTY;
      instr_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      stall_cycles_q <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      stall_cycles_q <= stall_cycles_d;
      error_q        <= error_d;
    end
  end

  // Entry payloads need no reset: validity is defined by head/count alone.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < SB_DEPTH; i++) sb_dest_q[i] <= sb_dest_d[i];
  end

  assign bus.oInstructionAccepted = accept;
  assign bus.oIssue               = issue;
  assign bus.oInstruction         = instr_q;
  assign bus.oPendingCount        = count_q;
  assign bus.oStalled             = stalled;
  assign bus.oStallCycles         = stall_cycles_q;
  assign bus.oError               = error_q;
endmodule

// File: tb/tb_issue_scoreboard_control.sv
// Bench for issue_scoreboard_control: two instances (youngest forwarding on
// and off) run the same directed programs against a queue-level model.
module tb_issue_scoreboard_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  issue_scoreboard_control_if #(.SB_DEPTH(4)) bus0 ();
  issue_scoreboard_control_if #(.SB_DEPTH(4)) bus1 ();

  issue_scoreboard_control #(.SB_DEPTH(4), .FWD_YOUNGEST(1'b1), .IMM_BITPOS(62))
    dut0 (.Clock(clk), .Reset(rst), .bus(bus0));
  issue_scoreboard_control #(.SB_DEPTH(4), .FWD_YOUNGEST(1'b0), .IMM_BITPOS(62))
    dut1 (.Clock(clk), .Reset(rst), .bus(bus1));

  logic        i_avail [2];
  logic [63:0] i_enc   [2];
  logic        i_wbv   [2];
  logic [15:0] i_wba   [2];
  logic        o_acc [2], o_issue [2], o_stall [2], o_err [2];
  logic [63:0] o_instr [2];
  logic [2:0]  o_cnt [2];
  logic [15:0] o_sc [2];

  assign bus0.iInstructionAvailable = i_avail[0];
  assign bus0.iEncodedInstruction   = i_enc[0];
  assign bus0.iWritebackValid       = i_wbv[0];
  assign bus0.iWritebackAddress     = i_wba[0];
  assign bus0.iExeBusy              = busy;
  assign bus0.iFlush                = flush;
  assign bus1.iInstructionAvailable = i_avail[1];
  assign bus1.iEncodedInstruction   = i_enc[1];
  assign bus1.iWritebackValid       = i_wbv[1];
  assign bus1.iWritebackAddress     = i_wba[1];
  assign bus1.iExeBusy              = busy;
  assign bus1.iFlush                = flush;
  assign o_acc[0] = bus0.oInstructionAccepted;  assign o_acc[1] = bus1.oInstructionAccepted;
  assign o_issue[0] = bus0.oIssue;              assign o_issue[1] = bus1.oIssue;
  assign o_instr[0] = bus0.oInstruction;        assign o_instr[1] = bus1.oInstruction;
  assign o_cnt[0] = bus0.oPendingCount;         assign o_cnt[1] = bus1.oPendingCount;
  assign o_stall[0] = bus0.oStalled;            assign o_stall[1] = bus1.oStalled;
  assign o_sc[0] = bus0.oStallCycles;           assign o_sc[1] = bus1.oStallCycles;
  assign o_err[0] = bus0.oError;                assign o_err[1] = bus1.oError;

  // Scenario controls and the fetch program shared by both instances
  logic        c_rst = 1'b1, c_busy = 1'b0, c_flush = 1'b0, c_fetch = 1'b0;
  logic        c_wb = 1'b0, c_wb_bad = 1'b0;
  logic [63:0] prog [16];
  int          plen = 0;
  int          pc [2];

  // Model: held instruction plus an oldest-first list of in-flight dests
  logic        m_held [2];
  logic [63:0] m_instr [2];
  logic [15:0] m_q [2][8];
  int          m_n [2];
  logic [15:0] m_sc [2];
  logic        m_err [2];

  logic [31:0] hist [2];
  int          scount = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [63:0] mk(logic imm, logic [15:0] d, logic [15:0] s1, logic [15:0] s0);
    return {1'b0, imm, 14'h0, d, s1, s0};
  endfunction

  task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic apply();
    rst = c_rst; busy = c_busy; flush = c_flush;
    for (int k = 0; k < 2; k++) begin
      i_avail[k] = c_fetch && (pc[k] < plen);
      i_enc[k]   = i_avail[k] ? prog[pc[k]] : 64'h0;
      i_wbv[k]   = c_wb_bad || (c_wb && (m_n[k] > 0));
      i_wba[k]   = c_wb_bad ? 16'h0099 : ((m_n[k] > 0) ? m_q[k][0] : 16'h0);
    end
  endtask

  task automatic check_update();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] hd, a, b;
      logic imm, haz, iss, acc, stl;
      hd  = m_instr[k][47:32];
      imm = m_instr[k][62];
      a   = imm ? hd : m_instr[k][15:0];
      b   = imm ? hd : m_instr[k][31:16];
      haz = 1'b0;
      for (int i = 0; i < m_n[k]; i++) begin
        if (m_q[k][i] == hd) haz = 1'b1;
        if (!(k == 0 && i == m_n[k] - 1) && (m_q[k][i] == a || m_q[k][i] == b)) haz = 1'b1;
      end
      iss = m_held[k] && !haz && !flush && !busy && (m_n[k] < 4);
      acc = !rst && i_avail[k] && !flush && (!m_held[k] || iss);
      stl = m_held[k] && !iss && !flush;
      chk("accepted", k, o_acc[k], acc);
      if (!rst) begin
        chk("issue", k, o_issue[k], iss);
        if (iss) chk("instruction", k, o_instr[k], m_instr[k]);
        chk("pending", k, o_cnt[k], m_n[k]);
        chk("stalled", k, o_stall[k], stl);
        chk("stall_cycles", k, o_sc[k], m_sc[k]);
        chk("error", k, o_err[k], m_err[k]);
      end
      hist[k][scount] = o_issue[k];
      if (rst) begin
        m_held[k] = 1'b0; m_instr[k] = '0; m_n[k] = 0; m_sc[k] = '0; m_err[k] = 1'b0;
      end else begin
        if (i_wbv[k]) begin
          if (m_n[k] == 0 || i_wba[k] != m_q[k][0]) m_err[k] = 1'b1;
          else begin
            for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
            m_n[k]--;
          end
        end
        if (iss) begin m_q[k][m_n[k]] = hd; m_n[k]++; end
        if (stl && m_sc[k] != 16'hFFFF) m_sc[k]++;
        if (flush) m_held[k] = 1'b0;
        else if (acc) begin m_held[k] = 1'b1; m_instr[k] = i_enc[k]; pc[k]++; end
        else if (iss) m_held[k] = 1'b0;
      end
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk); #1;
      apply();
      @(negedge clk);
      check_update();
      scount++;
    end
  endtask

  // Loads the program, pulses reset with fetch requested, restarts history
  task automatic start_scn(int len);
    plen = len; pc[0] = 0; pc[1] = 0;
    c_rst = 1'b1; c_fetch = 1'b1; c_busy = 1'b0; c_flush = 1'b0; c_wb = 1'b0; c_wb_bad = 1'b0;
    step(1);
    for (int k = 0; k < 2; k++) chk("accepted_in_reset", k, o_acc[k], 1'b0);
    c_rst = 1'b0;
    scount = 0; hist[0] = '0; hist[1] = '0;
  endtask

  task automatic check_zero(string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_issue"}, k, o_issue[k], 1'b0);
      chk({tag, "_instr"}, k, o_instr[k], 64'h0);
      chk({tag, "_pending"}, k, o_cnt[k], 3'd0);
      chk({tag, "_stalled"}, k, o_stall[k], 1'b0);
      chk({tag, "_stallcyc"}, k, o_sc[k], 16'h0);
      chk({tag, "_error"}, k, o_err[k], 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_held[k] = 1'b0; m_instr[k] = '0; m_n[k] = 0; m_sc[k] = '0; m_err[k] = 1'b0; pc[k] = 0;
    end
    for (int i = 0; i < 16; i++) prog[i] = '0;
    apply();

    // Reset state
    start_scn(0);
    c_fetch = 1'b0;
    step(1);
    check_zero("reset");

    // Independent stream, one retirement two cycles after each issue
    for (int i = 0; i < 8; i++) prog[i] = mk(1'b0, 16'h100 + 16'(i), 16'h200 + 16'(i), 16'h300 + 16'(i));
    start_scn(8);
    for (int s = 0; s < 12; s++) begin c_wb = (s >= 3 && s <= 10); step(1); end
    for (int k = 0; k < 2; k++) begin
      chk("stream_issue_pattern", k, hist[k][11:0], 12'h1FE);
      chk("stream_stallcyc", k, o_sc[k], 16'h0);
      chk("stream_pending", k, o_cnt[k], 3'd0);
    end

    // RAW against the youngest entry: forwarded on dut0, stalls on dut1
    prog[0] = mk(1'b0, 16'h0010, 16'h0001, 16'h0002);
    prog[1] = mk(1'b0, 16'h0040, 16'h0003, 16'h0010);
    start_scn(2);
    for (int s = 0; s < 7; s++) begin c_wb = (s == 4); step(1); end
    chk("raw_fwd_pattern", 0, hist[0][6:0], 7'h06);
    chk("raw_nofwd_pattern", 1, hist[1][6:0], 7'h22);
    chk("raw_nofwd_stallcyc", 1, o_sc[1], 16'd3);

    // RAW against an older entry stalls regardless of forwarding
    prog[0] = mk(1'b0, 16'h0020, 16'h0001, 16'h0002);
    prog[1] = mk(1'b0, 16'h0030, 16'h0003, 16'h0004);
    prog[2] = mk(1'b0, 16'h0050, 16'h0020, 16'h0005);
    start_scn(3);
    for (int s = 0; s < 8; s++) begin c_wb = (s == 5); step(1); end
    for (int k = 0; k < 2; k++) begin
      chk("raw_old_pattern", k, hist[k][7:0], 8'h46);
      chk("raw_old_stallcyc", k, o_sc[k], 16'd3);
    end

    // WAW holds until the matching entry itself retires
    prog[2] = mk(1'b0, 16'h0030, 16'h0008, 16'h0009);
    start_scn(3);
    for (int s = 0; s < 9; s++) begin c_wb = (s == 4 || s == 6); step(1); end
    for (int k = 0; k < 2; k++) begin
      chk("waw_pattern", k, hist[k][8:0], 9'h086);
      chk("waw_stallcyc", k, o_sc[k], 16'd4);
    end

    // Full scoreboard, then a busy execution unit
    for (int i = 0; i < 5; i++) prog[i] = mk(1'b0, 16'h60 + 16'(i), 16'h70 + 16'(2*i), 16'h71 + 16'(2*i));
    start_scn(5);
    step(7);
    for (int k = 0; k < 2; k++) begin
      chk("full_pattern", k, hist[k][6:0], 7'h1E);
      chk("full_pending", k, o_cnt[k], 3'd4);
      chk("full_stalled", k, o_stall[k], 1'b1);
    end
    c_wb = 1'b1; step(1); c_wb = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("full_pop_pending", k, o_cnt[k], 3'd4);
      chk("full_pop_stallcyc", k, o_sc[k], 16'd2);
    end
    c_busy = 1'b1; step(3); c_busy = 1'b0;
    step(1);
    for (int k = 0; k < 2; k++) begin
      chk("busy_stallcyc", k, o_sc[k], 16'd6);
      chk("resume_issue", k, o_issue[k], 1'b1);
      chk("resume_pending", k, o_cnt[k], 3'd3);
    end

    // Immediate form: src1 is not a source, so an older match is ignored
    prog[0] = mk(1'b0, 16'h0080, 16'h0001, 16'h0002);
    prog[1] = mk(1'b1, 16'h0090, 16'h0080, 16'h0003);
    start_scn(2);
    step(4);
    for (int k = 0; k < 2; k++) chk("imm_pattern", k, hist[k][3:0], 4'h6);

    // Flush of a stalled instruction, then a bad writeback
    prog[0] = mk(1'b0, 16'h0020, 16'h0001, 16'h0002);
    prog[1] = mk(1'b0, 16'h0021, 16'h0003, 16'h0004);
    prog[2] = mk(1'b0, 16'h0022, 16'h0005, 16'h0006);
    start_scn(3);
    step(2);
    c_busy = 1'b1; step(1);
    c_flush = 1'b1; step(1);
    for (int k = 0; k < 2; k++) begin
      chk("flush_accepted", k, o_acc[k], 1'b0);
      chk("flush_issue", k, o_issue[k], 1'b0);
      chk("flush_pending", k, o_cnt[k], 3'd1);
    end
    c_flush = 1'b0; c_busy = 1'b0; step(1);
    for (int k = 0; k < 2; k++) begin
      chk("post_flush_stalled", k, o_stall[k], 1'b0);
      chk("post_flush_issue", k, o_issue[k], 1'b0);
      chk("post_flush_accept", k, o_acc[k], 1'b1);
    end
    step(1);
    for (int k = 0; k < 2; k++) chk("post_flush_instr", k, o_instr[k], 64'h0000_0022_0005_0006);
    c_wb_bad = 1'b1; step(1); c_wb_bad = 1'b0;
    step(1);
    for (int k = 0; k < 2; k++) begin
      chk("wb_bad_error", k, o_err[k], 1'b1);
      chk("wb_bad_pending", k, o_cnt[k], 3'd2);
    end
    c_wb = 1'b1; step(1); c_wb = 1'b0;
    step(1);
    for (int k = 0; k < 2; k++) begin
      chk("error_sticky", k, o_err[k], 1'b1);
      chk("good_wb_pending", k, o_cnt[k], 3'd1);
    end

    // Reset while a WAW-blocked instruction is held
    prog[0] = mk(1'b0, 16'h0022, 16'h0007, 16'h0008);
    plen = 1; pc[0] = 0; pc[1] = 0;
    step(3);
    for (int k = 0; k < 2; k++) chk("pre_reset_stalled", k, o_stall[k], 1'b1);
    c_rst = 1'b1; step(1);
    c_rst = 1'b0; c_fetch = 1'b0; step(1);
    check_zero("mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard_control.md
# issue_scoreboard_control

Sits between instruction fetch and the InstructionDecode stage and decides, cycle by cycle, when a fetched 64-bit instruction may be presented to decode. It holds one instruction and tracks in-flight destination addresses in an in-order scoreboard. Issue is held on RAW or WAW hazards that decode's single last-destination forward cannot cover, on a busy execution unit, or on a full scoreboard. Branch flushes drop the held instruction.

## Interface
- SB_DEPTH, 4: scoreboard entries (max in-flight writes), power of two, 2..8
- FWD_YOUNGEST, 1: 1 = RAW match against the youngest in-flight entry is not a hazard, because decode forwards it
- IMM_BITPOS, 62: position of the immediate-operand flag in the instruction word
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- iInstructionAvailable  in  1  fetch has a valid instruction on iEncodedInstruction
- iEncodedInstruction  in  64  op[63:48], dest[47:32], src1[31:16], src0[15:0]
- oInstructionAccepted  out  1  fetch word consumed this cycle
- oIssue  out  1  drives decode iInstructionAvailable
- oInstruction  out  64  held instruction, valid while oIssue=1
- iExeBusy  in  1  execution unit cannot take a new operation
- iWritebackValid  in  1  a result is written this cycle
- iWritebackAddress  in  16  address written
- iFlush  in  1  branch taken, discard held/incoming instruction
- oPendingCount  out  log2(SB_DEPTH)+1  valid scoreboard entries
- oStalled  out  1  held instruction blocked this cycle
- oStallCycles  out  16  saturating count of stalled cycles
- oError  out  1  sticky; writeback out of order or with empty scoreboard

## Operation
- States: EMPTY (no held instruction), HELD. EMPTY→HELD on accept. HELD→EMPTY on issue without simultaneous accept, or on iFlush. HELD→HELD on issue with accept (back-to-back).
- Sources checked: imm flag=1 → dest[47:32] only (read-modify of dest), src1 ignored. imm=0 → src0 and src1.
- RAW hazard: a checked source equals the dest of any valid entry. If FWD_YOUNGEST=1, the youngest entry is excluded.
- WAW hazard: held dest equals the dest of any valid entry, youngest included.
- issue = HELD & !hazard & !iExeBusy & (oPendingCount<SB_DEPTH) & !iFlush.
- Hazard check uses registered scoreboard state. A writeback in the same cycle does not unblock until the next cycle.
- accept = iInstructionAvailable & !iFlush & (EMPTY | issue).
- On issue, push held dest at the tail. On iWritebackValid, pop the head.
  - If iWritebackAddress ≠ head dest, or the scoreboard is empty: set oError, leave the scoreboard unchanged.
  - Push and pop in the same cycle are both applied; the count is unchanged.
- iFlush: the held instruction is dropped and the incoming one is not accepted. Scoreboard entries remain and still retire.
- oStalled = HELD & !issue & !iFlush. oStallCycles increments when oStalled and saturates at 0xFFFF.

## Timing
- Reset values: state EMPTY, scoreboard empty, oIssue 0, oInstructionAccepted 0 (forced while Reset), oInstruction 0, oPendingCount 0, oStalled 0, oStallCycles 0, oError 0.
- Reset mid-operation discards the held instruction and all entries in one cycle.
- Accept at edge N → earliest oIssue during cycle N+1. Sustained throughput is one instruction per cycle when there are no hazards.
- oIssue/oInstruction are valid in the same cycle. Decode latches them at the end of that cycle.
- oIssue is combinational from registered state and iExeBusy/iFlush, with no path from iEncodedInstruction.
- Scoreboard full (count=SB_DEPTH) blocks issue. A pop that cycle still takes effect, so issue can resume the next cycle.

## Test plan
- Independent stream: 8 instructions, imm=0, distinct addresses, iExeBusy=0, one writeback 2 cycles after each issue → oIssue asserted 8 consecutive cycles starting the cycle after first accept, oStallCycles=0.
- RAW exemption: instrA dest 0x0010, then instrB src0=0x0010 with FWD_YOUNGEST=1 → back-to-back issue. Same with FWD_YOUNGEST=0 → B stalls until the cycle after A's writeback.
- Non-youngest RAW / WAW: issue A (dest 0x20), C (dest 0x30), then D (src1=0x20) → D stalls until A retires. D with dest 0x30 → stalls until C retires.
- Full and busy: SB_DEPTH=4, no writebacks, 5 instructions → 4 issue, oPendingCount=4, 5th stalls. iExeBusy=1 for 3 cycles → oStallCycles +3.
- Flush: held instruction stalled, iFlush pulse → no issue, EMPTY next cycle, oInstructionAccepted=0 that cycle, pending count unchanged.
- Writeback error: writeback address 0x99 while head=0x20 → oError=1 sticky, count unchanged. Reset mid-stall → all outputs at reset values the next cycle.
